// File: rtl/sr_cmd_debounce.sv
// Set/clear request front-end for the SR stage: sync, debounce, edge detect,
// and arbitration into spaced, mutually exclusive one-cycle s/r commands.
module sr_cmd_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 3,
    parameter bit CLR_PRIORITY    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req_raw,
    input  logic clr_req_raw,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);

    typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

    localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    // Bit 0 is the set line, bit 1 the clear line.
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] stable_q, stable_d;
    logic [1:0] stable_dly_q;
    logic [7:0] cnt_q [2];
    logic [7:0] cnt_d [2];
    logic [1:0] pend_q, pend_d;
    logic [1:0] evt, want;

    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       s_q, s_d;
    logic       r_q, r_d;
    logic       conf_q, conf_d;
    logic       serve;
    logic       win_clr;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = cnt_q[i] + 8'd1;
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = 8'd0;
            end else if (cnt_q[i] == DB_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = 8'd0;
            end
        end
    end

    assign evt  = stable_q & ~stable_dly_q;
    assign want = evt | pend_q;

    // A pending request may be served straight out of the last hold cycle.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pend_d  = pend_q | evt;
        s_d     = 1'b0;
        r_d     = 1'b0;
        conf_d  = 1'b0;
        serve   = 1'b0;
        win_clr = want[1] & (~want[0] | CLR_PRIORITY);
        unique case (state_q)
            IDLE: serve = 1'b1;
            PULSE: begin
                if (HOLD_CYCLES == 0) begin
                    serve = 1'b1;
                end else begin
                    state_d = HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (hold_q == 8'd0) serve = 1'b1;
                else hold_d = hold_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
        if (serve) begin
            state_d = IDLE;
            if (|want) begin
                state_d = PULSE;
                pend_d  = 2'b00;
                s_d     = ~win_clr;
                r_d     = win_clr;
                conf_d  = &want;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 2'b00;
            sync2_q      <= 2'b00;
            stable_q     <= 2'b00;
            stable_dly_q <= 2'b00;
            cnt_q[0]     <= 8'd0;
            cnt_q[1]     <= 8'd0;
            pend_q       <= 2'b00;
            state_q      <= IDLE;
            hold_q       <= 8'd0;
            s_q          <= 1'b0;
            r_q          <= 1'b0;
            conf_q       <= 1'b0;
        end else begin
            sync1_q      <= {clr_req_raw, set_req_raw};
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q[0]     <= cnt_d[0];
            cnt_q[1]     <= cnt_d[1];
            pend_q       <= pend_d;
            state_q      <= state_d;
            hold_q       <= hold_d;
            s_q          <= s_d;
            r_q          <= r_d;
            conf_q       <= conf_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign conflict = conf_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Scoreboard bench for sr_cmd_debounce: expected pulses are queued with their
// cycle number when stimulus is driven and matched as the DUTs emit them.
module tb_sr_cmd_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_raw = 1'b0;
    logic clr_raw = 1'b0;
    logic s, r, busy, conflict;
    logic s0, r0, busy0, conflict0;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int k;
    logic [63:0] q1[$];
    logic [63:0] q0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sr_cmd_debounce #(
        .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(3), .CLR_PRIORITY(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .set_req_raw(set_raw), .clr_req_raw(clr_raw),
        .s(s), .r(r), .busy(busy), .conflict(conflict)
    );

    sr_cmd_debounce #(
        .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(3), .CLR_PRIORITY(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst), .set_req_raw(set_raw), .clr_req_raw(clr_raw),
        .s(s0), .r(r0), .busy(busy0), .conflict(conflict0)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] rec(input int c, input logic se,
                                        input logic re, input logic cf);
        return {32'(c), 29'd0, se, re, cf};
    endfunction

    task automatic expect_both(input int c, input logic se, input logic re,
                               input logic cf);
        q1.push_back(rec(c, se, re, cf));
        q0.push_back(rec(c, se, re, cf));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        chk({tag, "_q1"}, 64'(q1.size()), 64'd0);
        chk({tag, "_q0"}, 64'(q0.size()), 64'd0);
        q1.delete();
        q0.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_s"}, s, 1'b0);
        chk({tag, "_r"}, r, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_conf"}, conflict, 1'b0);
        chk({tag, "_busy0"}, busy0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("excl", s & r, 1'b0);
            chk("excl0", s0 & r0, 1'b0);
            if (s | r | conflict) begin
                if (q1.size() == 0) chk("unexp", rec(cyc, s, r, conflict), 64'd0);
                else chk("pulse", rec(cyc, s, r, conflict), q1.pop_front());
            end
            if (s0 | r0 | conflict0) begin
                if (q0.size() == 0) chk("unexp0", rec(cyc, s0, r0, conflict0), 64'd0);
                else chk("pulse0", rec(cyc, s0, r0, conflict0), q0.pop_front());
            end
        end
    end

    initial begin
        idle(3);
        chk_zero("rst");
        rst = 1'b0;

        // Clean set: pulse D+3 negedges after the raw change, busy for H+1 cycles.
        k = cyc;
        set_raw = 1'b1;
        expect_both(k + 7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("busy1", busy, (cyc >= k + 7 && cyc <= k + 10));
        end
        set_raw = 1'b0;
        idle(10);
        drain("clean");

        // Three-cycle glitch is rejected.
        clr_raw = 1'b1;
        idle(3);
        clr_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("busy2", busy, 1'b0);
        end
        drain("glitch");

        // Four cycles is just enough.
        k = cyc;
        clr_raw = 1'b1;
        expect_both(k + 7, 1'b0, 1'b1, 1'b0);
        idle(4);
        clr_raw = 1'b0;
        idle(16);
        drain("edge4");

        // Simultaneous requests resolved by priority.
        k = cyc;
        set_raw = 1'b1;
        clr_raw = 1'b1;
        q1.push_back(rec(k + 7, 1'b0, 1'b1, 1'b1));
        q0.push_back(rec(k + 7, 1'b1, 1'b0, 1'b1));
        idle(12);
        set_raw = 1'b0;
        clr_raw = 1'b0;
        idle(12);
        drain("simul");

        // Clear arriving during hold is queued and served at P+H+1.
        k = cyc;
        set_raw = 1'b1;
        expect_both(k + 7, 1'b1, 1'b0, 1'b0);
        expect_both(k + 11, 1'b0, 1'b1, 1'b0);
        idle(2);
        clr_raw = 1'b1;
        idle(14);
        set_raw = 1'b0;
        clr_raw = 1'b0;
        idle(12);
        drain("queue");

        // Reset mid-hold with a set pending.
        k = cyc;
        clr_raw = 1'b1;
        expect_both(k + 7, 1'b0, 1'b1, 1'b0);
        idle(2);
        set_raw = 1'b1;
        idle(7);
        chk("busy5", busy, 1'b1);
        rst = 1'b1;
        set_raw = 1'b0;
        clr_raw = 1'b0;
        #1;
        chk_zero("rst5a");
        idle(3);
        chk_zero("rst5b");
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("busy5r", busy, 1'b0);
        end
        drain("rsthold");

        // Set held high across reset release.
        rst = 1'b1;
        set_raw = 1'b1;
        idle(3);
        k = cyc;
        rst = 1'b0;
        expect_both(k + 7, 1'b1, 1'b0, 1'b0);
        idle(25);
        set_raw = 1'b0;
        idle(12);
        drain("held");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
